count_pulse_debouncer: RTL and testbench

//   Cleans a bouncy mechanical push-button into a glitch-free Count level for
//   the 4-bit ripple counter. Sits directly upstream of it: Count drives the

---
 rtl/count_pulse_debouncer.sv | 105 ++++++++++
 tb/tb_count_pulse_debouncer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/count_pulse_debouncer.sv
// Push-button debouncer: 2-flop synchroniser feeding a four-state qualification FSM.
// Count, Press_pulse, Release_pulse and Busy are all driven straight from flops.
module count_pulse_debouncer #(
    parameter int DEBOUNCE_CYCLES = 10,
    parameter int CNT_W           = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Btn_raw,
    output logic Count,
    output logic Press_pulse,
    output logic Release_pulse,
    output logic Busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        PRESSED,
        WAIT_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             btn_s_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             count_q, count_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             busy_q, busy_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            btn_s_q <= 1'b0;
        end else begin
            sync1_q <= Btn_raw;
            btn_s_q <= sync1_q;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         if (btn_s_q) state_d = WAIT_PRESS;
            WAIT_PRESS: begin
                if (!btn_s_q)                 state_d = IDLE;
                else if (timer_q == TIMER_LAST) state_d = PRESSED;
            end
            PRESSED:      if (!btn_s_q) state_d = WAIT_RELEASE;
            WAIT_RELEASE: begin
                if (btn_s_q)                  state_d = PRESSED;
                else if (timer_q == TIMER_LAST) state_d = IDLE;
            end
            default:      state_d = IDLE;
        endcase

        // Timer restarts on every state entry; it only advances while qualifying,
        // and a WAIT state leaves before reaching TIMER_LAST+1, so it never wraps.
        timer_d = '0;
        if (state_d == state_q && (state_q == WAIT_PRESS || state_q == WAIT_RELEASE))
            timer_d = timer_q + 1'b1;
    end

    always_comb begin
        count_d   = (state_d == PRESSED) || (state_d == WAIT_RELEASE);
        press_d   = (state_q == WAIT_PRESS) && (state_d == PRESSED);
        release_d = (state_q == WAIT_RELEASE) && (state_d == IDLE);
        busy_d    = (state_d == WAIT_PRESS) || (state_d == WAIT_RELEASE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            press_q   <= press_d;
            release_q <= release_d;
            busy_q    <= busy_d;
        end
    end

    assign Count         = count_q;
    assign Press_pulse   = press_q;
    assign Release_pulse = release_q;
    assign Busy          = busy_q;

endmodule

// File: tb/tb_count_pulse_debouncer.sv
// Bench for count_pulse_debouncer: run-length reference model feeding a scoreboard,
// a table of button segments, and hand-written reset/latency sequences.
module tb_count_pulse_debouncer;

    localparam int D = 10;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic btn_raw = 1'b0;
    logic count, press_pulse, release_pulse, busy;
    logic [3:0] ctr = 4'd0;

    int total = 0;
    int bad   = 0;
    int seen_press = 0;
    int seen_rel   = 0;

    // Reference model: synchroniser history plus run length of samples disagreeing with Count.
    bit m_s1 = 1'b0, m_s2 = 1'b0, m_count = 1'b0;
    int m_run = 0;

    typedef struct {
        logic c;
        logic p;
        logic r;
        logic b;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic btn;
        int   cycles;
        logic exp_count;
        int   exp_press;
        int   exp_rel;
    } seg_t;
    seg_t segs[10];

    always #5 clk = ~clk;

    count_pulse_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .Clk          (clk),
        .Reset        (reset),
        .Btn_raw      (btn_raw),
        .Count        (count),
        .Press_pulse  (press_pulse),
        .Release_pulse(release_pulse),
        .Busy         (busy)
    );

    // Downstream 4-bit ripple counter: advances on Count falling edge, shares Reset.
    always @(negedge count or posedge reset) begin
        if (reset) ctr <= 4'd0;
        else       ctr <= ctr + 4'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        m_count = 1'b0;
        m_run = 0;
    endtask

    // One clock: drive btn at negedge, update model at posedge, compare 1 ns later.
    task automatic step(input logic b);
        exp_t e;
        @(negedge clk);
        btn_raw = b;
        @(posedge clk);
        e = '{c: 1'b0, p: 1'b0, r: 1'b0, b: 1'b0};
        if (reset) begin
            model_clear();
        end else begin
            if (m_s2 != m_count) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_count = ~m_count;
                    e.p = m_count;
                    e.r = ~m_count;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = b;
            e.c = m_count;
            e.b = (m_run != 0);
        end
        sb_q.push_back(e);
        #1;
        if (press_pulse) seen_press++;
        if (release_pulse) seen_rel++;
        e = sb_q.pop_front();
        check("sb_outs", 32'({count, press_pulse, release_pulse, busy}),
              32'({e.c, e.p, e.r, e.b}));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        segs[0] = '{btn: 1'b0, cycles: 15, exp_count: 1'b0, exp_press: 0, exp_rel: 1};
        segs[1] = '{btn: 1'b1, cycles: 3,  exp_count: 1'b0, exp_press: 0, exp_rel: 0};
        segs[2] = '{btn: 1'b0, cycles: 2,  exp_count: 1'b0, exp_press: 0, exp_rel: 0};
        segs[3] = '{btn: 1'b1, cycles: 4,  exp_count: 1'b0, exp_press: 0, exp_rel: 0};
        segs[4] = '{btn: 1'b0, cycles: 15, exp_count: 1'b0, exp_press: 0, exp_rel: 0};
        segs[5] = '{btn: 1'b1, cycles: 15, exp_count: 1'b1, exp_press: 1, exp_rel: 0};
        segs[6] = '{btn: 1'b0, cycles: 5,  exp_count: 1'b1, exp_press: 0, exp_rel: 0};
        segs[7] = '{btn: 1'b1, cycles: 15, exp_count: 1'b1, exp_press: 0, exp_rel: 0};
        segs[8] = '{btn: 1'b0, cycles: 15, exp_count: 1'b0, exp_press: 0, exp_rel: 1};
        segs[9] = '{btn: 1'b1, cycles: 15, exp_count: 1'b1, exp_press: 1, exp_rel: 0};

        // Reset held while the button chatters: outputs must stay quiet.
        fork
            repeat (12) #7 btn_raw = ~btn_raw;
            repeat (8) begin
                @(posedge clk);
                #1 check("rst_outs", 32'({count, press_pulse, release_pulse, busy}), 32'd0);
            end
        join
        btn_raw = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) step(1'b0);
        check("idle_busy", 32'(busy), 32'd0);

        // Clean press: Count rises on edge 13, Busy high over edges 3..12.
        for (int k = 1; k <= 15; k++) begin
            step(1'b1);
            check("press_count", 32'(count), 32'(k >= 13));
            check("press_pulse", 32'(press_pulse), 32'(k == 13));
            check("press_busy", 32'(busy), 32'(k >= 3 && k < 13));
        end

        for (int i = 0; i < 10; i++) begin
            seen_press = 0;
            seen_rel = 0;
            for (int c = 0; c < segs[i].cycles; c++) step(segs[i].btn);
            check($sformatf("seg%0d_count", i), 32'(count), 32'(segs[i].exp_count));
            check($sformatf("seg%0d_press", i), 32'(seen_press), 32'(segs[i].exp_press));
            check($sformatf("seg%0d_rel", i), 32'(seen_rel), 32'(segs[i].exp_rel));
        end
        repeat (15) step(1'b0);
        check("tbl_end_count", 32'(count), 32'd0);

        // Ripple counter chained downstream: 5 clean cycles, then bounce-only bursts.
        reset = 1'b1;
        model_clear();
        repeat (2) step(1'b0);
        reset = 1'b0;
        repeat (3) step(1'b0);
        check("ctr_reset", 32'(ctr), 32'd0);
        repeat (5) begin
            repeat (15) step(1'b1);
            repeat (15) step(1'b0);
        end
        check("ctr_five", 32'(ctr), 32'd5);
        repeat (3) begin
            repeat (3) step(1'b1);
            repeat (3) step(1'b0);
        end
        repeat (15) step(1'b0);
        check("ctr_bursts", 32'(ctr), 32'd5);
        check("bursts_busy", 32'(busy), 32'd0);

        // Reset mid-press with button held: Count drops at once, then requalifies.
        repeat (15) step(1'b1);
        check("hold_count", 32'(count), 32'd1);
        #2 reset = 1'b1;
        model_clear();
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_ctr", 32'(ctr), 32'd0);
        repeat (2) step(1'b1);
        reset = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step(1'b1);
            check("rq_count", 32'(count), 32'(k >= 13));
            check("rq_pulse", 32'(press_pulse), 32'(k == 13));
        end
        repeat (15) step(1'b0);
        check("final_ctr", 32'(ctr), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
